// File: rtl/icache_port_scheduler_if.sv
// Signal bundle between the frontend/ICache side and icache_port_scheduler.
// The scheduler takes the slave view; the frontend and ICache drive the master view.
interface icache_port_scheduler_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_WIDTH = 128
);
    logic                             flush_i;
    logic [1:0]                       ifu_req_i;
    logic [1:0]                       ifu_req_uncached_i;
    logic [1:0][ADDR_WIDTH-1:0]       ifu_addr_i;
    logic [1:0]                       ifu_ready_o;
    logic [1:0]                       ifu_rvalid_o;
    logic [1:0][LINE_WIDTH-1:0]       ifu_rdata_o;
    logic                             pf_req_i;
    logic [ADDR_WIDTH-1:0]            pf_addr_i;
    logic                             pf_ready_o;
    logic                             pf_done_o;
    logic [1:0]                       icache_rreq_o;
    logic [1:0]                       icache_rreq_uncached_o;
    logic [1:0][ADDR_WIDTH-1:0]       icache_raddr_o;
    logic [1:0]                       icache_rreq_ack_i;
    logic [1:0]                       icache_rvalid_i;
    logic [1:0][LINE_WIDTH-1:0]       icache_rdata_i;

    modport slave (
        input  flush_i, ifu_req_i, ifu_req_uncached_i, ifu_addr_i, pf_req_i, pf_addr_i,
               icache_rreq_ack_i, icache_rvalid_i, icache_rdata_i,
        output ifu_ready_o, ifu_rvalid_o, ifu_rdata_o, pf_ready_o, pf_done_o,
               icache_rreq_o, icache_rreq_uncached_o, icache_raddr_o
    );

    modport master (
        output flush_i, ifu_req_i, ifu_req_uncached_i, ifu_addr_i, pf_req_i, pf_addr_i,
               icache_rreq_ack_i, icache_rvalid_i, icache_rdata_i,
        input  ifu_ready_o, ifu_rvalid_o, ifu_rdata_o, pf_ready_o, pf_done_o,
               icache_rreq_o, icache_rreq_uncached_o, icache_raddr_o
    );
endinterface

// File: rtl/icache_port_scheduler.sv
// Shares the two ICache read ports between IFU demand fetches and the next-line
// prefetcher (port 1 only), with one request/ack/data FSM per port and flush squashing.
module icache_port_scheduler #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_WIDTH = 128,
    parameter bit          PF_ENABLE  = 1'b1
) (
    input logic                    clk,
    input logic                    rst_n,
    icache_port_scheduler_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;
    typedef enum logic {OwnDemand, OwnPf} owner_e;

    state_e                state_q [2];
    state_e                state_d [2];
    logic [ADDR_WIDTH-1:0] addr_q  [2];
    logic [ADDR_WIDTH-1:0] addr_d  [2];
    logic [1:0]            unc_q, unc_d;
    logic [1:0]            stale_q, stale_d;
    owner_e                owner_q, owner_d;

    logic [1:0]                 idle;
    logic [1:0]                 ready;
    logic [1:0]                 demand_acc;
    logic [1:0]                 live;
    logic                       pf_ready;
    logic                       pf_acc;
    logic [1:0][LINE_WIDTH-1:0] rdata;

    always_comb begin
        idle       = '0;
        ready      = '0;
        demand_acc = '0;
        for (int p = 0; p < 2; p++) begin
            idle[p]       = (state_q[p] == StIdle);
            ready[p]      = idle[p] & ~bus.flush_i;
            demand_acc[p] = bus.ifu_req_i[p] & ready[p];
        end
        // Demand on port 1 always wins over prefetch.
        pf_ready = PF_ENABLE & ready[1] & ~bus.ifu_req_i[1];
        pf_acc   = pf_ready & bus.pf_req_i;
    end

    always_comb begin
        owner_d = owner_q;
        unc_d   = unc_q;
        stale_d = stale_q;
        for (int p = 0; p < 2; p++) begin
            state_d[p] = state_q[p];
            addr_d[p]  = addr_q[p];
            unique case (state_q[p])
                StIdle: begin
                    if (demand_acc[p]) begin
                        state_d[p] = StReq;
                        addr_d[p]  = bus.ifu_addr_i[p];
                        unc_d[p]   = bus.ifu_req_uncached_i[p];
                        if (p == 1) owner_d = OwnDemand;
                    end else if (p == 1 && pf_acc) begin
                        state_d[p] = StReq;
                        addr_d[p]  = bus.pf_addr_i;
                        unc_d[p]   = 1'b0;
                        owner_d    = OwnPf;
                    end
                end
                StReq: begin
                    if (bus.flush_i) stale_d[p] = 1'b1;
                    if (bus.icache_rreq_ack_i[p]) begin
                        state_d[p] = bus.icache_rvalid_i[p] ? StIdle : StResp;
                    end
                end
                StResp: begin
                    if (bus.flush_i) stale_d[p] = 1'b1;
                    if (bus.icache_rvalid_i[p]) state_d[p] = StIdle;
                end
                default: state_d[p] = StIdle;
            endcase
            if (state_d[p] == StIdle) stale_d[p] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < 2; p++) begin
                state_q[p] <= StIdle;
                addr_q[p]  <= '0;
            end
            unc_q   <= '0;
            stale_q <= '0;
            owner_q <= OwnDemand;
        end else begin
            for (int p = 0; p < 2; p++) begin
                state_q[p] <= state_d[p];
                addr_q[p]  <= addr_d[p];
            end
            unc_q   <= unc_d;
            stale_q <= stale_d;
            owner_q <= owner_d;
        end
    end

    assign rdata = bus.icache_rdata_i;

    always_comb begin
        live                       = '0;
        bus.icache_rreq_o          = '0;
        bus.icache_rreq_uncached_o = '0;
        bus.icache_raddr_o         = '0;
        for (int p = 0; p < 2; p++) begin
            bus.icache_rreq_o[p]          = (state_q[p] == StReq);
            bus.icache_rreq_uncached_o[p] = unc_q[p] & (state_q[p] == StReq);
            bus.icache_raddr_o[p]         = addr_q[p];
            // Stale or flush-coincident responses finish the FSM but are swallowed.
            live[p] = bus.icache_rvalid_i[p] & ~idle[p] & ~stale_q[p] & ~bus.flush_i;
        end
        bus.ifu_ready_o     = ready;
        bus.pf_ready_o      = pf_ready;
        bus.ifu_rvalid_o[0] = live[0];
        bus.ifu_rvalid_o[1] = live[1] & (owner_q == OwnDemand);
        bus.pf_done_o       = PF_ENABLE & live[1] & (owner_q == OwnPf);
        bus.ifu_rdata_o     = rdata;
    end
endmodule

// File: tb/tb_icache_port_scheduler.sv
// Directed table-driven bench for icache_port_scheduler plus hand-written reset sequences.
module tb_icache_port_scheduler;
    localparam logic [31:0] A0 = 32'h1c00_0000;
    localparam logic [31:0] A1 = 32'h1c00_0040;
    localparam logic [31:0] B  = 32'h1c00_0080;
    localparam logic [31:0] Z  = 32'h0;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    icache_port_scheduler_if #(.ADDR_WIDTH(32), .LINE_WIDTH(128)) bus ();

    icache_port_scheduler #(
        .ADDR_WIDTH(32),
        .LINE_WIDTH(128),
        .PF_ENABLE (1'b1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && ((bus.icache_rreq_ack_i & ~bus.icache_rreq_o) != 2'b00))
            $error("protocol: ICache ack with no outstanding request");
    end

    typedef struct {
        bit          flush;
        bit [1:0]    req;
        bit [1:0]    unc;
        bit [31:0]   a0;
        bit [31:0]   a1;
        bit          pf;
        bit [31:0]   pa;
        bit [1:0]    ack;
        bit [1:0]    rv;
        bit [1:0]    e_ready;
        bit          e_pfr;
        bit [1:0]    e_rreq;
        bit [1:0]    e_runc;
        bit [31:0]   e_ra0;
        bit [31:0]   e_ra1;
        bit [1:0]    e_rvalid;
        bit          e_pfd;
    } vec_t;

    function automatic vec_t r(bit flush, bit [1:0] req, bit [1:0] unc, bit [31:0] a0,
                               bit [31:0] a1, bit pf, bit [31:0] pa, bit [1:0] ack,
                               bit [1:0] rv, bit [1:0] e_ready, bit e_pfr, bit [1:0] e_rreq,
                               bit [1:0] e_runc, bit [31:0] e_ra0, bit [31:0] e_ra1,
                               bit [1:0] e_rvalid, bit e_pfd);
        vec_t v;
        v.flush = flush; v.req = req; v.unc = unc; v.a0 = a0; v.a1 = a1;
        v.pf = pf; v.pa = pa; v.ack = ack; v.rv = rv;
        v.e_ready = e_ready; v.e_pfr = e_pfr; v.e_rreq = e_rreq; v.e_runc = e_runc;
        v.e_ra0 = e_ra0; v.e_ra1 = e_ra1; v.e_rvalid = e_rvalid; v.e_pfd = e_pfd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.flush_i            = 1'b0;
        bus.ifu_req_i          = '0;
        bus.ifu_req_uncached_i = '0;
        bus.ifu_addr_i         = '0;
        bus.pf_req_i           = 1'b0;
        bus.pf_addr_i          = '0;
        bus.icache_rreq_ack_i  = '0;
        bus.icache_rvalid_i    = '0;
        bus.icache_rdata_i     = '0;
    endtask

    vec_t          tbl [$];
    logic [127:0]  d0, d1;

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        clear_inputs();

        //           fl req  unc   a0 a1 pf pa  ack   rv   | rdy  pfr rreq  runc  ra0 ra1 rval  pfd
        // Demand on port 0: accept, request, ack at c3, data at c5.
        tbl.push_back(r(0, 2'b01, 2'b00, A0, Z, 0, Z, 2'b00, 2'b00, 2'b11, 1, 2'b00, 2'b00, Z, Z, 2'b00, 0));
        tbl.push_back(r(0, 2'b00, 2'b00, Z, Z, 0, Z, 2'b00, 2'b00, 2'b10, 1, 2'b01, 2'b00, A0, Z, 2'b00, 0));
        tbl.push_back(r(0, 2'b00, 2'b00, Z, Z, 0, Z, 2'b00, 2'b00, 2'b10, 1, 2'b01, 2'b00, A0, Z, 2'b00, 0));
        tbl.push_back(r(0, 2'b00, 2'b00, Z, Z, 0, Z, 2'b01, 2'b00, 2'b10, 1, 2'b01, 2'b00, A0, Z, 2'b00, 0));
        tbl.push_back(r(0, 2'b00, 2'b00, Z, Z, 0, Z, 2'b00, 2'b00, 2'b10, 1, 2'b00, 2'b00, Z, Z, 2'b00, 0));
        tbl.push_back(r(0, 2'b00, 2'b00, Z, Z, 0, Z, 2'b00, 2'b01, 2'b10, 1, 2'b00, 2'b00, Z, Z, 2'b01, 0));
        tbl.push_back(r(0, 2'b00, 2'b00, Z, Z, 0, Z, 2'b00, 2'b00, 2'b11, 1, 2'b00, 2'b00, Z, Z, 2'b00, 0));
        // Demand and prefetch together on port 1: demand (uncached) wins; ack+rvalid same cycle.
        tbl.push_back(r(0, 2'b10, 2'b10, Z, B, 1, A1, 2'b00, 2'b00, 2'b11, 0, 2'b00, 2'b00, Z, Z, 2'b00, 0));
        tbl.push_back(r(0, 2'b00, 2'b00, Z, Z, 0, Z, 2'b00, 2'b00, 2'b01, 0, 2'b10, 2'b10, Z, B, 2'b00, 0));
        tbl.push_back(r(0, 2'b00, 2'b00, Z, Z, 0, Z, 2'b10, 2'b10, 2'b01, 0, 2'b10, 2'b10, Z, B, 2'b10, 0));
        // Back-to-back prefetch; completion pulses pf_done only.
        tbl.push_back(r(0, 2'b00, 2'b00, Z, Z, 1, A1, 2'b00, 2'b00, 2'b11, 1, 2'b00, 2'b00, Z, Z, 2'b00, 0));
        tbl.push_back(r(0, 2'b00, 2'b00, Z, Z, 0, Z, 2'b10, 2'b00, 2'b01, 0, 2'b10, 2'b00, Z, A1, 2'b00, 0));
        tbl.push_back(r(0, 2'b00, 2'b00, Z, Z, 0, Z, 2'b00, 2'b10, 2'b01, 0, 2'b00, 2'b00, Z, Z, 2'b00, 1));
        // Demand right after prefetch takes ownership back.
        tbl.push_back(r(0, 2'b10, 2'b00, Z, B, 0, Z, 2'b00, 2'b00, 2'b11, 0, 2'b00, 2'b00, Z, Z, 2'b00, 0));
        tbl.push_back(r(0, 2'b00, 2'b00, Z, Z, 0, Z, 2'b10, 2'b10, 2'b01, 0, 2'b10, 2'b00, Z, B, 2'b10, 0));
        // Simultaneous accept on both ports.
        tbl.push_back(r(0, 2'b11, 2'b01, B, A0, 0, Z, 2'b00, 2'b00, 2'b11, 0, 2'b00, 2'b00, Z, Z, 2'b00, 0));
        tbl.push_back(r(0, 2'b00, 2'b00, Z, Z, 0, Z, 2'b00, 2'b00, 2'b00, 0, 2'b11, 2'b01, B, A0, 2'b00, 0));
        tbl.push_back(r(0, 2'b00, 2'b00, Z, Z, 0, Z, 2'b11, 2'b00, 2'b00, 0, 2'b11, 2'b01, B, A0, 2'b00, 0));
        tbl.push_back(r(0, 2'b00, 2'b00, Z, Z, 0, Z, 2'b00, 2'b11, 2'b00, 0, 2'b00, 2'b00, Z, Z, 2'b11, 0));
        tbl.push_back(r(0, 2'b00, 2'b00, Z, Z, 0, Z, 2'b00, 2'b00, 2'b11, 1, 2'b00, 2'b00, Z, Z, 2'b00, 0));
        // Flush in REQ while ack is withheld: request holds, response swallowed.
        tbl.push_back(r(0, 2'b01, 2'b00, A0, Z, 0, Z, 2'b00, 2'b00, 2'b11, 1, 2'b00, 2'b00, Z, Z, 2'b00, 0));
        tbl.push_back(r(1, 2'b00, 2'b00, Z, Z, 0, Z, 2'b00, 2'b00, 2'b00, 0, 2'b01, 2'b00, A0, Z, 2'b00, 0));
        tbl.push_back(r(0, 2'b00, 2'b00, Z, Z, 0, Z, 2'b00, 2'b00, 2'b10, 1, 2'b01, 2'b00, A0, Z, 2'b00, 0));
        tbl.push_back(r(0, 2'b00, 2'b00, Z, Z, 0, Z, 2'b00, 2'b00, 2'b10, 1, 2'b01, 2'b00, A0, Z, 2'b00, 0));
        tbl.push_back(r(0, 2'b00, 2'b00, Z, Z, 0, Z, 2'b00, 2'b00, 2'b10, 1, 2'b01, 2'b00, A0, Z, 2'b00, 0));
        tbl.push_back(r(0, 2'b00, 2'b00, Z, Z, 0, Z, 2'b01, 2'b00, 2'b10, 1, 2'b01, 2'b00, A0, Z, 2'b00, 0));
        tbl.push_back(r(0, 2'b00, 2'b00, Z, Z, 0, Z, 2'b00, 2'b01, 2'b10, 1, 2'b00, 2'b00, Z, Z, 2'b00, 0));
        tbl.push_back(r(0, 2'b00, 2'b00, Z, Z, 0, Z, 2'b00, 2'b00, 2'b11, 1, 2'b00, 2'b00, Z, Z, 2'b00, 0));
        // Flush coincident with rvalid in RESP, then flush blocking an idle accept.
        tbl.push_back(r(0, 2'b10, 2'b00, Z, B, 0, Z, 2'b00, 2'b00, 2'b11, 0, 2'b00, 2'b00, Z, Z, 2'b00, 0));
        tbl.push_back(r(0, 2'b00, 2'b00, Z, Z, 0, Z, 2'b10, 2'b00, 2'b01, 0, 2'b10, 2'b00, Z, B, 2'b00, 0));
        tbl.push_back(r(1, 2'b00, 2'b00, Z, Z, 0, Z, 2'b00, 2'b10, 2'b00, 0, 2'b00, 2'b00, Z, Z, 2'b00, 0));
        tbl.push_back(r(1, 2'b01, 2'b00, A0, Z, 0, Z, 2'b00, 2'b00, 2'b00, 0, 2'b00, 2'b00, Z, Z, 2'b00, 0));
        tbl.push_back(r(0, 2'b00, 2'b00, Z, Z, 0, Z, 2'b00, 2'b00, 2'b11, 1, 2'b00, 2'b00, Z, Z, 2'b00, 0));
        // Flush during a prefetch: pf_done is swallowed.
        tbl.push_back(r(0, 2'b00, 2'b00, Z, Z, 1, A1, 2'b00, 2'b00, 2'b11, 1, 2'b00, 2'b00, Z, Z, 2'b00, 0));
        tbl.push_back(r(1, 2'b00, 2'b00, Z, Z, 0, Z, 2'b10, 2'b00, 2'b00, 0, 2'b10, 2'b00, Z, A1, 2'b00, 0));
        tbl.push_back(r(0, 2'b00, 2'b00, Z, Z, 0, Z, 2'b00, 2'b10, 2'b01, 0, 2'b00, 2'b00, Z, Z, 2'b00, 0));
        tbl.push_back(r(0, 2'b00, 2'b00, Z, Z, 0, Z, 2'b00, 2'b00, 2'b11, 1, 2'b00, 2'b00, Z, Z, 2'b00, 0));

        // Reset held for 3 cycles.
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("reset_rreq", bus.icache_rreq_o, 2'b00);
            chk("reset_rvalid", bus.ifu_rvalid_o, 2'b00);
            chk("reset_pf_done", bus.pf_done_o, 1'b0);
            chk("reset_raddr0", bus.icache_raddr_o[0], Z);
        end
        rst_n = 1'b1;
        #1;
        chk("post_reset_ready", bus.ifu_ready_o, 2'b11);
        chk("post_reset_pf_ready", bus.pf_ready_o, 1'b1);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            d0 = {$urandom, $urandom, $urandom, $urandom};
            d1 = {$urandom, $urandom, $urandom, $urandom};
            bus.flush_i            = tbl[i].flush;
            bus.ifu_req_i          = tbl[i].req;
            bus.ifu_req_uncached_i = tbl[i].unc;
            bus.ifu_addr_i[0]      = tbl[i].a0;
            bus.ifu_addr_i[1]      = tbl[i].a1;
            bus.pf_req_i           = tbl[i].pf;
            bus.pf_addr_i          = tbl[i].pa;
            bus.icache_rreq_ack_i  = tbl[i].ack;
            bus.icache_rvalid_i    = tbl[i].rv;
            bus.icache_rdata_i[0]  = d0;
            bus.icache_rdata_i[1]  = d1;
            #1;
            chk($sformatf("v%0d_ready", i), bus.ifu_ready_o, tbl[i].e_ready);
            chk($sformatf("v%0d_pf_ready", i), bus.pf_ready_o, tbl[i].e_pfr);
            chk($sformatf("v%0d_rreq", i), bus.icache_rreq_o, tbl[i].e_rreq);
            chk($sformatf("v%0d_runc", i), bus.icache_rreq_uncached_o, tbl[i].e_runc);
            chk($sformatf("v%0d_rvalid", i), bus.ifu_rvalid_o, tbl[i].e_rvalid);
            chk($sformatf("v%0d_pf_done", i), bus.pf_done_o, tbl[i].e_pfd);
            if (tbl[i].e_rreq[0]) chk($sformatf("v%0d_raddr0", i), bus.icache_raddr_o[0], tbl[i].e_ra0);
            if (tbl[i].e_rreq[1]) chk($sformatf("v%0d_raddr1", i), bus.icache_raddr_o[1], tbl[i].e_ra1);
            if (tbl[i].e_rvalid[0]) chk($sformatf("v%0d_rdata0", i), bus.ifu_rdata_o[0], d0);
            if (tbl[i].e_rvalid[1]) chk($sformatf("v%0d_rdata1", i), bus.ifu_rdata_o[1], d1);
        end

        // Async reset while port 0 is in REQ drops the request immediately.
        @(negedge clk);
        clear_inputs();
        bus.ifu_req_i     = 2'b01;
        bus.ifu_addr_i[0] = A0;
        @(negedge clk);
        clear_inputs();
        #1;
        chk("midrst_rreq_before", bus.icache_rreq_o, 2'b01);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_rreq_during", bus.icache_rreq_o, 2'b00);
        chk("midrst_raddr0", bus.icache_raddr_o[0], Z);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_ready_after", bus.ifu_ready_o, 2'b11);
        @(negedge clk);
        #1;
        chk("midrst_rreq_after", bus.icache_rreq_o, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
